// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: ALU control, ALUOp and
// function-field encodings, and the stage FSM state type.
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MUL
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_AND = 4'b0100;
    localparam logic [3:0] FN_OR  = 4'b0101;
    localparam logic [3:0] FN_SLT = 4'b1010;
    localparam logic [3:0] FN_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_WRITE
    } exec_state_e;

endpackage

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle,
// W steps after start; done is high during the cycle of the final step.
module exec_mul_seq #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] product_lo
);
    localparam int unsigned CNT_W = $clog2(W);

    logic [CNT_W-1:0] count_q, count_d;
    logic             run_q, run_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;

    always_comb begin
        count_d  = count_q;
        run_d    = run_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done     = run_q && (count_q == CNT_W'(W - 1));
        if (start) begin
            count_d  = '0;
            run_d    = 1'b1;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
        end else if (run_q) begin
            // Only the low W bits of the product are kept, so bits shifted
            // out of the multiplicand can be dropped.
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CNT_W'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            run_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            count_q  <= count_d;
            run_q    <= run_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign product_lo = acc_q;

endmodule

// File: rtl/execute_stage_pipe.sv
// Execute stage: single-cycle ALU and branch-target adder with a valid/ready
// output register. Define EXEC_STAGE_MUL_EN to add the iterative MUL path.
module execute_stage_pipe
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FUNCT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_Valid,
    output logic              in_Ready,
    input  logic [DATA_W-1:0] in_Read_Data_1,
    input  logic [DATA_W-1:0] in_Read_Data_2,
    input  logic [DATA_W-1:0] in_Immediate,
    input  logic              in_ALUSrc,
    input  logic [1:0]        in_ALUOp,
    input  logic [DATA_W-1:0] in_PC_plus_two,
    output logic              O_Valid,
    input  logic              in_Out_Ready,
    output logic [DATA_W-1:0] O_ALUResult,
    output logic              O_Zero,
    output logic [DATA_W-1:0] O_addResult,
    output logic              O_Busy
);
    // Function field is compared at no less than 4 bits so any extra
    // high bits must be zero to match a defined code.
    localparam int unsigned FW = (FUNCT_W > 4) ? FUNCT_W : 4;

    logic [FW-1:0]     funct;
    alu_ctrl_e         fn_ctrl;
    alu_ctrl_e         ctrl;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] branch_tgt;
    logic              accept;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] addr_q, addr_d;

    always_comb begin
        funct   = FW'(in_Immediate[FUNCT_W-1:0]);
        fn_ctrl = ALU_ADD;
        if (funct == FW'(FN_SUB)) fn_ctrl = ALU_SUB;
        if (funct == FW'(FN_AND)) fn_ctrl = ALU_AND;
        if (funct == FW'(FN_OR))  fn_ctrl = ALU_OR;
        if (funct == FW'(FN_SLT)) fn_ctrl = ALU_SLT;
`ifdef EXEC_STAGE_MUL_EN
        if (funct == FW'(FN_MUL)) fn_ctrl = ALU_MUL;
`endif
        case (in_ALUOp)
            ALUOP_ADD:   ctrl = ALU_ADD;
            ALUOP_SUB:   ctrl = ALU_SUB;
            ALUOP_FUNCT: ctrl = fn_ctrl;
            ALUOP_OR:    ctrl = ALU_OR;
            default:     ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        op_b       = in_ALUSrc ? in_Immediate : in_Read_Data_2;
        branch_tgt = (in_Immediate << 1) + in_PC_plus_two;
        case (ctrl)
            ALU_SUB: alu_res = in_Read_Data_1 - op_b;
            ALU_AND: alu_res = in_Read_Data_1 & op_b;
            ALU_OR:  alu_res = in_Read_Data_1 | op_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}},
                                ($signed(in_Read_Data_1) < $signed(op_b))};
            default: alu_res = in_Read_Data_1 + op_b;
        endcase
    end

`ifdef EXEC_STAGE_MUL_EN
    exec_state_e       state_q, state_d;
    logic [DATA_W-1:0] addr_hold_q, addr_hold_d;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    exec_mul_seq #(.W(DATA_W)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start      (mul_start),
        .a          (in_Read_Data_1),
        .b          (op_b),
        .done       (mul_done),
        .product_lo (mul_product)
    );

    assign in_Ready = (state_q == ST_IDLE) && (!valid_q || in_Out_Ready);
    assign O_Busy   = (state_q != ST_IDLE);
`else
    assign in_Ready = !valid_q || in_Out_Ready;
    assign O_Busy   = 1'b0;
`endif

    assign accept = in_Valid && in_Ready;

    always_comb begin
        valid_d  = valid_q && !in_Out_Ready;
        result_d = result_q;
        zero_d   = zero_q;
        addr_d   = addr_q;
`ifdef EXEC_STAGE_MUL_EN
        state_d     = state_q;
        addr_hold_d = addr_hold_q;
        mul_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && (ctrl == ALU_MUL)) begin
                    mul_start   = 1'b1;
                    addr_hold_d = branch_tgt;
                    state_d     = ST_MUL;
                end else if (accept) begin
                    valid_d  = 1'b1;
                    result_d = alu_res;
                    zero_d   = (alu_res == '0);
                    addr_d   = branch_tgt;
                end
            end
            ST_MUL: begin
                if (mul_done) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (!valid_q || in_Out_Ready) begin
                    valid_d  = 1'b1;
                    result_d = mul_product;
                    zero_d   = (mul_product == '0);
                    addr_d   = addr_hold_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`else
        if (accept) begin
            valid_d  = 1'b1;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            addr_d   = branch_tgt;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            addr_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            addr_q   <= addr_d;
        end
    end

`ifdef EXEC_STAGE_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_hold_q <= addr_hold_d;
        end
    end
`endif

    assign O_Valid     = valid_q;
    assign O_ALUResult = result_q;
    assign O_Zero      = zero_q;
    assign O_addResult = addr_q;

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Directed bench for execute_stage_pipe (DATA_W=16) with an arithmetic
// reference model; covers both builds of EXEC_STAGE_MUL_EN.
module tb_execute_stage_pipe;

    logic        clk;
    logic        rst;
    logic        in_Valid;
    logic        in_Ready;
    logic [15:0] in_Read_Data_1;
    logic [15:0] in_Read_Data_2;
    logic [15:0] in_Immediate;
    logic        in_ALUSrc;
    logic [1:0]  in_ALUOp;
    logic [15:0] in_PC_plus_two;
    logic        O_Valid;
    logic        in_Out_Ready;
    logic [15:0] O_ALUResult;
    logic        O_Zero;
    logic [15:0] O_addResult;
    logic        O_Busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        zero;
        logic [15:0] tgt;
    } exp_t;

    exp_t exp_q[$];

    execute_stage_pipe #(.DATA_W(16), .FUNCT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_Valid       (in_Valid),
        .in_Ready       (in_Ready),
        .in_Read_Data_1 (in_Read_Data_1),
        .in_Read_Data_2 (in_Read_Data_2),
        .in_Immediate   (in_Immediate),
        .in_ALUSrc      (in_ALUSrc),
        .in_ALUOp       (in_ALUOp),
        .in_PC_plus_two (in_PC_plus_two),
        .O_Valid        (O_Valid),
        .in_Out_Ready   (in_Out_Ready),
        .O_ALUResult    (O_ALUResult),
        .O_Zero         (O_Zero),
        .O_addResult    (O_addResult),
        .O_Busy         (O_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: what the stage must produce for one bundle.
    function automatic exp_t model(input logic [1:0] op, input logic src,
                                   input logic [15:0] a, input logic [15:0] rb,
                                   input logic [15:0] imm, input logic [15:0] pc);
        exp_t        e;
        logic [15:0] b;
        logic [3:0]  fn;
        b  = src ? imm : rb;
        fn = imm[3:0];
        case (op)
            2'd0: e.res = a + b;
            2'd1: e.res = a - b;
            2'd3: e.res = a | b;
            default: begin
                case (fn)
                    4'd2:  e.res = a - b;
                    4'd4:  e.res = a & b;
                    4'd5:  e.res = a | b;
                    4'd10: e.res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
`ifdef EXEC_STAGE_MUL_EN
                    4'd8:  e.res = 16'(longint'(a) * longint'(b));
`endif
                    default: e.res = a + b;
                endcase
            end
        endcase
        e.zero = (e.res == 16'd0);
        e.tgt  = 16'(longint'(imm) * 2 + longint'(pc));
        return e;
    endfunction

    // Compare process: drains results against the model, checks stall stability.
    logic  held;
    exp_t  held_val;
    initial held = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", O_Valid, 1);
                check("stall_result", O_ALUResult, held_val.res);
                check("stall_zero", O_Zero, held_val.zero);
                check("stall_target", O_addResult, held_val.tgt);
            end
            if (O_Valid && !in_Out_Ready) begin
                check("stall_in_ready", in_Ready, 0);
            end
`ifndef EXEC_STAGE_MUL_EN
            check("busy_tied_low", O_Busy, 0);
`endif
            if (O_Valid && in_Out_Ready) begin
                check("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("model_result", O_ALUResult, e.res);
                    check("model_zero", O_Zero, e.zero);
                    check("model_target", O_addResult, e.tgt);
                end
            end
            held     = O_Valid && !in_Out_Ready;
            held_val = '{res: O_ALUResult, zero: O_Zero, tgt: O_addResult};
            if (in_Valid && in_Ready) begin
                exp_q.push_back(model(in_ALUOp, in_ALUSrc, in_Read_Data_1,
                                      in_Read_Data_2, in_Immediate, in_PC_plus_two));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic src, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] imm, input logic [15:0] pc);
        in_Valid       = 1'b1;
        in_ALUOp       = op;
        in_ALUSrc      = src;
        in_Read_Data_1 = a;
        in_Read_Data_2 = b;
        in_Immediate   = imm;
        in_PC_plus_two = pc;
    endtask

    logic [1:0]  t_op  [8] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2};
    logic        t_src [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] t_a   [8] = '{16'h0003, 16'h00F0, 16'hFF0F, 16'h1200,
                               16'h0100, 16'h0002, 16'hFFFF, 16'h8000};
    logic [15:0] t_b   [8] = '{16'h0005, 16'h0F0F, 16'h0FF0, 16'h0034,
                               16'h0023, 16'hFFFF, 16'h1111, 16'h2222};
    logic [15:0] t_imm [8] = '{16'h0000, 16'h0000, 16'h0004, 16'h0005,
                               16'h0007, 16'h000A, 16'h0001, 16'hFFF2};
    logic [15:0] t_exp [8] = '{16'hFFFE, 16'h0FFF, 16'h0F00, 16'h1234,
                               16'h0123, 16'h0000, 16'h0000, 16'h800E};

    initial begin
        int n;
        logic ready_seen;
        rst = 1'b1;
        in_Out_Ready = 1'b1;
        drive(2'd0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        in_Valid = 1'b0;
        step();
        step();
        check("rst_valid", O_Valid, 0);
        check("rst_busy", O_Busy, 0);
        check("rst_result", O_ALUResult, 0);
        check("rst_target", O_addResult, 0);
        check("rst_zero", O_Zero, 1);
        check("rst_in_ready", in_Ready, 1);

        // First accept on the first edge after reset release: SUB 5-5.
        rst = 1'b0;
        drive(2'b10, 1'b0, 16'd5, 16'd5, 16'h0002, 16'h0000);
        step();
        check("sub_valid", O_Valid, 1);
        check("sub_result", O_ALUResult, 16'h0000);
        check("sub_zero", O_Zero, 1);

        drive(2'b10, 1'b0, 16'hFFFF, 16'h0001, 16'h000A, 16'h0000);
        step();
        check("slt_signed", O_ALUResult, 16'h0001);
        check("slt_zero", O_Zero, 0);

        drive(2'b00, 1'b1, 16'h0001, 16'h0000, 16'h0004, 16'h0010);
        step();
        check("branch_fwd", O_addResult, 16'h0018);
        check("branch_fwd_alu", O_ALUResult, 16'h0005);
        drive(2'b00, 1'b1, 16'h0003, 16'h0000, 16'hFFFE, 16'h0002);
        step();
        check("branch_back", O_addResult, 16'hFFFE);
        check("branch_back_alu", O_ALUResult, 16'h0001);

        for (int i = 0; i < 8; i++) begin
            drive(t_op[i], t_src[i], t_a[i], t_b[i], t_imm[i], 16'h0040);
            step();
            check($sformatf("table_%0d", i), O_ALUResult, t_exp[i]);
            check($sformatf("table_valid_%0d", i), O_Valid, 1);
        end

        // Function 1000: multi-cycle MUL when enabled, single-cycle ADD otherwise.
        drive(2'b10, 1'b0, 16'h0123, 16'h0010, 16'h0008, 16'h0100);
        step();
        in_Valid = 1'b0;
`ifdef EXEC_STAGE_MUL_EN
        n = 0;
        ready_seen = 1'b0;
        while (O_Busy && n < 40) begin
            if (in_Ready || O_Valid) ready_seen = 1'b1;
            in_Read_Data_1 = 16'hDEAD;
            in_Read_Data_2 = 16'hBEEF;
            in_Immediate   = 16'h0FF0;
            step();
            n++;
        end
        check("mul_busy_cycles", n, 17);
        check("mul_ready_low", ready_seen, 0);
        check("mul_valid", O_Valid, 1);
        check("mul_result", O_ALUResult, 16'h1230);
        check("mul_target", O_addResult, 16'h0110);
`else
        check("fn8_valid", O_Valid, 1);
        check("fn8_add", O_ALUResult, 16'h0133);
        check("fn8_busy", O_Busy, 0);
        check("fn8_target", O_addResult, 16'h0110);
`endif
        step();
        check("drained", O_Valid, 0);

        // Output stall with a pending bundle whose data keeps changing.
        in_Out_Ready = 1'b0;
        drive(2'b00, 1'b0, 16'd7, 16'd8, 16'h0000, 16'h0000);
        step();
        check("stall_load", O_ALUResult, 16'd15);
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 1'b0, 16'(100 + i), 16'd4, 16'h0000, 16'h0000);
            #1;
            check("stall_not_ready", in_Ready, 0);
            step();
            check("stall_hold", O_ALUResult, 16'd15);
            check("stall_hold_valid", O_Valid, 1);
        end
        drive(2'b01, 1'b0, 16'd9, 16'd4, 16'h0000, 16'h0000);
        in_Out_Ready = 1'b1;
        #1;
        check("drain_ready", in_Ready, 1);
        step();
        check("no_bubble_valid", O_Valid, 1);
        check("no_bubble_result", O_ALUResult, 16'd5);
        in_Valid = 1'b0;
        step();
        check("post_drain_valid", O_Valid, 0);

        // Reset during the fifth cycle of a MUL.
        drive(2'b10, 1'b0, 16'h0123, 16'h0010, 16'h0008, 16'h0100);
        step();
        in_Valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("abort_valid", O_Valid, 0);
        check("abort_busy", O_Busy, 0);
        check("abort_zero", O_Zero, 1);
        check("abort_result", O_ALUResult, 0);
        step();
        rst = 1'b0;
        drive(2'b00, 1'b0, 16'd2, 16'd3, 16'h0000, 16'h0000);
        step();
        check("after_abort_valid", O_Valid, 1);
        check("after_abort_add", O_ALUResult, 16'd5);
        in_Valid = 1'b0;
        repeat (3) step();
        check("model_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
